// File: rtl/bus_ctrl_pkg.sv
// rtl/bus_ctrl_pkg.sv - shared types and status decode for the bus command controller
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_TW,
    ST_T4
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_MEMR,
    CMD_MEMW,
    CMD_IOR,
    CMD_IOW,
    CMD_INTA
  } cmd_t;

  localparam logic [2:0] SN_INTA    = 3'b000;
  localparam logic [2:0] SN_IOR     = 3'b001;
  localparam logic [2:0] SN_IOW     = 3'b010;
  localparam logic [2:0] SN_HALT    = 3'b011;
  localparam logic [2:0] SN_CODE    = 3'b100;
  localparam logic [2:0] SN_MEMR    = 3'b101;
  localparam logic [2:0] SN_MEMW    = 3'b110;
  localparam logic [2:0] SN_PASSIVE = 3'b111;

  // Code fetch is a memory read; HALT and passive start no bus cycle.
  function automatic cmd_t decode_status(input logic [2:0] s_n);
    cmd_t c;
    case (s_n)
      SN_INTA:          c = CMD_INTA;
      SN_IOR:           c = CMD_IOR;
      SN_IOW:           c = CMD_IOW;
      SN_CODE, SN_MEMR: c = CMD_MEMR;
      SN_MEMW:          c = CMD_MEMW;
      default:          c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_wait_timer.sv
// rtl/bus_cycle_ctrl_wait_timer.sv - minimum-wait down counter and wait-state timeout counter
module bus_wait_timer
  import bus_ctrl_pkg::*;
#(
  parameter int WAIT_MEM = 0,
  parameter int WAIT_IO  = 1,
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic wait_st,
  input  logic tw,
  input  logic sel_io,
  output logic wait_done,
  output logic timeout
);

  localparam logic [CNT_W-1:0] WAIT_MEM_C = CNT_W'(WAIT_MEM);
  localparam logic [CNT_W-1:0] WAIT_IO_C  = CNT_W'(WAIT_IO);
  localparam logic [CNT_W:0]   TMO_LIMIT  = (CNT_W+1)'(TIMEOUT);
  localparam bit               TMO_EN     = (TIMEOUT != 0);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W:0]   tmo_next;

  // Load the per-space minimum in T2, count it down through T3/TW, hold at zero.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (load) begin
      wait_cnt_d = sel_io ? WAIT_IO_C : WAIT_MEM_C;
    end else if (wait_st && (wait_cnt_q != '0)) begin
      wait_cnt_d = wait_cnt_q - 1'b1;
    end
  end

  // Clear in T2, count TW cycles, saturate at all-ones.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (load) begin
      tmo_cnt_d = '0;
    end else if (tw && (tmo_cnt_q != '1)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  // The current TW is included, so the TIMEOUT-th wait state is the last one.
  assign tmo_next  = {1'b0, tmo_cnt_q} + (CNT_W+1)'(1);
  assign wait_done = (wait_cnt_q == '0);
  assign timeout   = TMO_EN && tw && (tmo_next >= TMO_LIMIT);

endmodule

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - 8086/8088 bus command controller with wait states and timeout
module bus_cycle_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int WAIT_MEM  = 0,
  parameter int WAIT_IO   = 1,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 255,
  parameter int ADV_WRITE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] s_n,
  input  logic       aen_n,
  input  logic       cen,
  input  logic       ready,
  output logic       mrdc_n,
  output logic       mwtc_n,
  output logic       amwc_n,
  output logic       iorc_n,
  output logic       iowc_n,
  output logic       aiowc_n,
  output logic       inta_n,
  output logic       ale,
  output logic       dtr,
  output logic       den,
  output logic       mce,
  output logic       busy,
  output logic       bus_err
);

  state_t state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  cmd_t   new_cmd;
  logic   err_q, err_d;
  logic   start;
  logic   load, wait_st, tw, sel_io;
  logic   wait_done, timeout;
  logic   rd_ph, wr_ph, adv_ph, gate;

  assign new_cmd = decode_status(s_n);
  assign start   = (new_cmd != CMD_NONE) && !aen_n;
  assign wait_st = (state_q == ST_T3) || (state_q == ST_TW);
  assign tw      = (state_q == ST_TW);
  assign sel_io  = (cmd_q == CMD_IOR) || (cmd_q == CMD_IOW) || (cmd_q == CMD_INTA);

  bus_wait_timer #(
    .WAIT_MEM (WAIT_MEM),
    .WAIT_IO  (WAIT_IO),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .wait_st   (wait_st),
    .tw        (tw),
    .sel_io    (sel_io),
    .wait_done (wait_done),
    .timeout   (timeout)
  );

  // Next-state logic; the command is latched only when a cycle starts.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    err_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_T1;
          cmd_d   = new_cmd;
        end
      end
      ST_T1: state_d = ST_T2;
      ST_T2: begin
        state_d = ST_T3;
        load    = 1'b1;
      end
      ST_T3, ST_TW: begin
        if (timeout) begin
          state_d = ST_T4;
          err_d   = 1'b1;
        end else if (!wait_done || !ready) begin
          state_d = ST_TW;
        end else begin
          state_d = ST_T4;
        end
      end
      ST_T4: begin
        if (start) begin
          state_d = ST_T1;
          cmd_d   = new_cmd;
        end else begin
          state_d = ST_IDLE;
          cmd_d   = CMD_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cmd_d   = CMD_NONE;
      end
    endcase
  end

  // State, latched command and bus-error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NONE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
    end
  end

  // Output decode from state and latched command, then live cen/aen_n gating.
  always_comb begin
    rd_ph   = (state_q == ST_T2) || wait_st;
    wr_ph   = wait_st;
    adv_ph  = (ADV_WRITE != 0) ? rd_ph : wr_ph;
    gate    = cen && !aen_n;
    mrdc_n  = !(rd_ph  && (cmd_q == CMD_MEMR) && gate);
    iorc_n  = !(rd_ph  && (cmd_q == CMD_IOR)  && gate);
    inta_n  = !(rd_ph  && (cmd_q == CMD_INTA) && gate);
    mwtc_n  = !(wr_ph  && (cmd_q == CMD_MEMW) && gate);
    iowc_n  = !(wr_ph  && (cmd_q == CMD_IOW)  && gate);
    amwc_n  = !(adv_ph && (cmd_q == CMD_MEMW) && gate);
    aiowc_n = !(adv_ph && (cmd_q == CMD_IOW)  && gate);
    ale     = (state_q == ST_T1);
    dtr     = ((state_q == ST_T1) || rd_ph) ?
              ((cmd_q == CMD_MEMW) || (cmd_q == CMD_IOW)) : 1'b1;
    den     = rd_ph && cen;
    mce     = (state_q == ST_T1) && (cmd_q == CMD_INTA);
    busy    = (state_q != ST_IDLE);
    bus_err = err_q && (state_q == ST_T4);
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - self-checking bench for bus_cycle_ctrl
module tb_bus_cycle_ctrl;

  localparam int WAIT_MEM = 0;
  localparam int WAIT_IO  = 1;
  localparam int TIMEOUT  = 4;

  localparam int PH_IDLE = 0;
  localparam int PH_T1   = 1;
  localparam int PH_T2   = 2;
  localparam int PH_W    = 3;
  localparam int PH_T4   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] s_n;
  logic       aen_n, cen, ready;

  logic mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n;
  logic ale, dtr, den, mce, busy, bus_err;
  logic b_mrdc_n, b_mwtc_n, b_amwc_n, b_iorc_n, b_iowc_n, b_aiowc_n, b_inta_n;
  logic b_ale, b_dtr, b_den, b_mce, b_busy, b_bus_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_cycle_ctrl #(
    .WAIT_MEM(WAIT_MEM), .WAIT_IO(WAIT_IO), .CNT_W(8), .TIMEOUT(TIMEOUT), .ADV_WRITE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_n(s_n), .aen_n(aen_n), .cen(cen), .ready(ready),
    .mrdc_n(mrdc_n), .mwtc_n(mwtc_n), .amwc_n(amwc_n), .iorc_n(iorc_n),
    .iowc_n(iowc_n), .aiowc_n(aiowc_n), .inta_n(inta_n), .ale(ale), .dtr(dtr),
    .den(den), .mce(mce), .busy(busy), .bus_err(bus_err)
  );

  bus_cycle_ctrl #(
    .WAIT_MEM(WAIT_MEM), .WAIT_IO(WAIT_IO), .CNT_W(8), .TIMEOUT(TIMEOUT), .ADV_WRITE(0)
  ) dut_nadv (
    .clk(clk), .rst_n(rst_n), .s_n(s_n), .aen_n(aen_n), .cen(cen), .ready(ready),
    .mrdc_n(b_mrdc_n), .mwtc_n(b_mwtc_n), .amwc_n(b_amwc_n), .iorc_n(b_iorc_n),
    .iowc_n(b_iowc_n), .aiowc_n(b_aiowc_n), .inta_n(b_inta_n), .ale(b_ale), .dtr(b_dtr),
    .den(b_den), .mce(b_mce), .busy(b_busy), .bus_err(b_bus_err)
  );

  logic [14:0] obs;
  assign obs = {mrdc_n, mwtc_n, amwc_n, iorc_n, iowc_n, aiowc_n, inta_n,
                ale, dtr, den, mce, busy, bus_err, b_amwc_n, b_aiowc_n};

  // Expected pins for a bus phase, from the command's strobe family and the gating inputs.
  function automatic logic [14:0] exp_vec(input int ph, input logic [2:0] sn,
                                          input bit cen_v, input bit aen_v, input bit err);
    bit memr, memw, ior, iow, inta, wr, g, rd_on, wr_on, adv_on, nadv_on, xfer;
    memr    = (ph != PH_IDLE) && (sn == 3'b100 || sn == 3'b101);
    memw    = (ph != PH_IDLE) && (sn == 3'b110);
    ior     = (ph != PH_IDLE) && (sn == 3'b001);
    iow     = (ph != PH_IDLE) && (sn == 3'b010);
    inta    = (ph != PH_IDLE) && (sn == 3'b000);
    wr      = memw || iow;
    g       = cen_v && !aen_v;
    rd_on   = (ph == PH_T2 || ph == PH_W) && g;
    wr_on   = (ph == PH_W) && g;
    adv_on  = rd_on;
    nadv_on = wr_on;
    xfer    = (ph == PH_T1 || ph == PH_T2 || ph == PH_W);
    return {!(memr && rd_on), !(memw && wr_on), !(memw && adv_on),
            !(ior && rd_on), !(iow && wr_on), !(iow && adv_on), !(inta && rd_on),
            ph == PH_T1, xfer ? wr : 1'b1, (ph == PH_T2 || ph == PH_W) && cen_v,
            (ph == PH_T1) && inta, ph != PH_IDLE, (ph == PH_T4) && err,
            !(memw && nadv_on), !(iow && nadv_on)};
  endfunction

  task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(tag, obs, exp_vec(PH_IDLE, 3'b111, cen, aen_n, 1'b0));
    end
  endtask

  // One bus cycle: ready stays low for the first d wait decisions (T3 is decision 0).
  // The number of TW states is max(minimum wait, d), capped at TIMEOUT with a bus error.
  task automatic do_txn(input logic [2:0] sn, input int d, input bit drop_cen, input string tag);
    int  w, n;
    bit  err;
    w   = (sn == 3'b100 || sn == 3'b101 || sn == 3'b110) ? WAIT_MEM : WAIT_IO;
    n   = (d > w) ? d : w;
    err = 1'b0;
    if (TIMEOUT != 0 && n >= TIMEOUT) begin
      n   = TIMEOUT;
      err = 1'b1;
    end
    s_n = sn;
    @(posedge clk); #1;
    chk({tag, ".t1"}, obs, exp_vec(PH_T1, sn, cen, aen_n, err));
    s_n = 3'b111;
    @(posedge clk); #1;
    chk({tag, ".t2"}, obs, exp_vec(PH_T2, sn, cen, aen_n, err));
    if (drop_cen) cen = 1'b0;
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      chk({tag, (k == 0) ? ".t3" : ".tw"}, obs, exp_vec(PH_W, sn, cen, aen_n, err));
      ready = (k >= d);
    end
    ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".t4"}, obs, exp_vec(PH_T4, sn, cen, aen_n, err));
    cen = 1'b1;
  endtask

  initial begin
    logic [2:0] codes [6];
    logic [2:0] sn;
    codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    rst_n = 1'b0; s_n = 3'b111; aen_n = 1'b0; cen = 1'b1; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", obs, exp_vec(PH_IDLE, 3'b111, 1'b1, 1'b0, 1'b0));
    rst_n = 1'b1;

    idle_cycles(10, "passive");
    s_n = 3'b011;
    idle_cycles(3, "halt");
    s_n = 3'b101; aen_n = 1'b1;
    idle_cycles(3, "aen_block");
    aen_n = 1'b0; s_n = 3'b111;
    idle_cycles(1, "aen_release");

    do_txn(3'b101, 0, 1'b0, "memr");
    idle_cycles(2, "memr_idle");
    do_txn(3'b001, 3, 1'b0, "ior_wait");
    idle_cycles(1, "ior_idle");
    do_txn(3'b110, 0, 1'b0, "memw");
    idle_cycles(1, "memw_idle");
    do_txn(3'b010, 9, 1'b0, "iow_tmo");
    idle_cycles(1, "iow_idle");
    do_txn(3'b000, 0, 1'b0, "inta_a");
    do_txn(3'b000, 1, 1'b0, "inta_b2b");
    idle_cycles(1, "inta_idle");
    do_txn(3'b000, 2, 1'b1, "inta_cen");
    idle_cycles(1, "cen_idle");
    do_txn(3'b100, 4, 1'b0, "code_tmo");
    do_txn(3'b110, 2, 1'b1, "memw_cen_b2b");
    idle_cycles(1, "b2b_idle");

    for (int i = 0; i < 40; i++) begin
      sn = codes[$urandom_range(0, 5)];
      do_txn(sn, $urandom_range(0, 6), ($urandom_range(0, 7) == 0), "rand");
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3), "rand_idle");
    end
    idle_cycles(1, "rand_end");

    s_n = 3'b110;
    @(posedge clk); #1;
    chk("mreset.t1", obs, exp_vec(PH_T1, 3'b110, cen, aen_n, 1'b0));
    s_n = 3'b111;
    @(posedge clk); #1;
    chk("mreset.t2", obs, exp_vec(PH_T2, 3'b110, cen, aen_n, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("mreset.async", obs, exp_vec(PH_IDLE, 3'b111, cen, aen_n, 1'b0));
    @(posedge clk); #1;
    chk("mreset.hold", obs, exp_vec(PH_IDLE, 3'b111, cen, aen_n, 1'b0));
    rst_n = 1'b1;
    idle_cycles(2, "mreset.idle");
    do_txn(3'b001, 0, 1'b0, "after_reset");
    idle_cycles(2, "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
